// File: rtl/operand_bypass_unit_pkg.sv
// Shared processor constants and the pipeline slot record used by the operand bypass unit.
package operand_bypass_unit_pkg;

   localparam int REG_W    = 16;
   localparam int REG_ID_W = 4;
   localparam int NUM_REGS = 16;
   localparam logic [REG_ID_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic                valid;
      logic [REG_ID_W-1:0] dst;
      logic                is_load;
      logic [REG_W-1:0]    data;
   } slot_t;

   function automatic logic slot_hit(input slot_t s, input logic [REG_ID_W-1:0] src);
      return s.valid && (s.dst == src);
   endfunction

endpackage

// File: rtl/operand_bypass_unit_slot.sv
// One pipeline tracking slot: valid, destination, load flag and data, cleared asynchronously.
module bypass_slot
   import operand_bypass_unit_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  slot_t d,
   output slot_t q
);

   // NOTE: sequential state uses non-blocking assignments so every slot samples its
   // upstream neighbour's pre-edge value, giving a true shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/operand_bypass_unit.sv
// Operand bypass unit: tracks EX/MEM/WB destinations, forwards results to decode, detects load-use stalls.
module operand_bypass_unit
   import operand_bypass_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_ID_W-1:0] src1,
   input  logic [REG_ID_W-1:0] src2,
   input  logic                src1_used,
   input  logic                src2_used,
   input  logic [REG_ID_W-1:0] dst,
   input  logic                dst_we,
   input  logic                is_load,
   input  logic [REG_W-1:0]    rf_rdata1,
   input  logic [REG_W-1:0]    rf_rdata2,
   input  logic [REG_W-1:0]    ex_result,
   input  logic [REG_W-1:0]    mem_result,
   input  logic                flush,
   output logic [REG_W-1:0]    op1,
   output logic [REG_W-1:0]    op2,
   output logic                stall,
   output logic                wb_wen,
   output logic [REG_ID_W-1:0] wb_reg,
   output logic [REG_W-1:0]    wb_data
);

   slot_t ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;

   // Youngest producer wins; a load still in EX has no data yet and is covered by the stall.
   function automatic logic [REG_W-1:0] resolve(
      input logic [REG_ID_W-1:0] src,
      input logic [REG_W-1:0]    rf,
      input slot_t               ex_s,
      input slot_t               mem_s,
      input slot_t               wb_s,
      input logic [REG_W-1:0]    ex_val,
      input logic [REG_W-1:0]    mem_val
   );
      if (src == ZERO_REG)
         return '0;
      else if (slot_hit(ex_s, src) && !ex_s.is_load)
         return ex_val;
      else if (slot_hit(mem_s, src))
         return mem_s.is_load ? mem_val : mem_s.data;
      else if (slot_hit(wb_s, src))
         return wb_s.data;
      else
         return rf;
   endfunction

   assign stall = !flush && id_valid && ex_q.valid && ex_q.is_load &&
                  ((src1_used && (src1 == ex_q.dst)) || (src2_used && (src2 == ex_q.dst)));

   // NOTE: every field gets a default first so no path through always_comb can infer a latch.
   always_comb begin
      ex_d         = '0;
      ex_d.valid   = id_valid && dst_we && (dst != ZERO_REG) && !stall && !flush;
      ex_d.dst     = dst;
      ex_d.is_load = is_load;

      mem_d        = ex_q;
      mem_d.data   = ex_result;

      wb_d         = mem_q;
      wb_d.data    = mem_q.is_load ? mem_result : mem_q.data;
   end

   always_comb begin
      op1 = resolve(src1, rf_rdata1, ex_q, mem_q, wb_q, ex_result, mem_result);
      op2 = resolve(src2, rf_rdata2, ex_q, mem_q, wb_q, ex_result, mem_result);
   end

   bypass_slot u_ex  (.clk(clk), .rst(rst), .en(1'b1), .d(ex_d),  .q(ex_q));
   bypass_slot u_mem (.clk(clk), .rst(rst), .en(1'b1), .d(mem_d), .q(mem_q));
   bypass_slot u_wb  (.clk(clk), .rst(rst), .en(1'b1), .d(wb_d),  .q(wb_q));

   assign wb_wen  = wb_q.valid;
   assign wb_reg  = wb_q.dst;
   assign wb_data = wb_q.data;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed bench for operand_bypass_unit: hand-computed forwarding, stall, flush and reset vectors.
module tb_operand_bypass_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [3:0]  src1, src2, dst;
   logic        src1_used, src2_used, dst_we, is_load;
   logic [15:0] rf_rdata1, rf_rdata2, ex_result, mem_result;
   logic        flush;
   logic [15:0] op1, op2, wb_data;
   logic        stall, wb_wen;
   logic [3:0]  wb_reg;

   int n_vec = 0;
   int n_err = 0;

   operand_bypass_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .src1(src1), .src2(src2), .src1_used(src1_used), .src2_used(src2_used),
      .dst(dst), .dst_we(dst_we), .is_load(is_load),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ex_result(ex_result), .mem_result(mem_result), .flush(flush),
      .op1(op1), .op2(op2), .stall(stall),
      .wb_wen(wb_wen), .wb_reg(wb_reg), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                        input logic u2, input logic [3:0] d, input logic we, input logic ld);
      id_valid  = 1'b1;
      src1 = s1; src1_used = u1;
      src2 = s2; src2_used = u2;
      dst  = d;  dst_we    = we; is_load = ld;
   endtask

   task automatic idle();
      id_valid = 1'b0;
      src1 = 4'd0; src1_used = 1'b0;
      src2 = 4'd0; src2_used = 1'b0;
      dst  = 4'd0; dst_we    = 1'b0; is_load = 1'b0;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      flush = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      rf_rdata1 = 16'hAAAA; rf_rdata2 = 16'h5555;
      ex_result = 16'h0; mem_result = 16'h0;
      idle();
      issue(4'd1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
      #2;
      check("reset_wb_wen", {15'd0, wb_wen}, 16'h0);
      check("reset_stall",  {15'd0, stall},  16'h0);
      check("reset_op1_rf", op1, 16'hAAAA);
      check("reset_op2_r0", op2, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      drain();

      // ALU result forwarded from EX, then from MEM, then written back
      rf_rdata1 = 16'h0000; rf_rdata2 = 16'h0000;
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
      step();
      ex_result = 16'h1234;
      issue(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("ex_fwd_op1",   op1, 16'h1234);
      check("ex_fwd_stall", {15'd0, stall}, 16'h0);
      step();
      ex_result = 16'h9999; mem_result = 16'h5A5A;
      issue(4'd0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
      #1;
      check("mem_fwd_alu_op2", op2, 16'h1234);
      idle();
      step();
      #1;
      check("wb_wen_r3",  {15'd0, wb_wen}, 16'h1);
      check("wb_reg_r3",  {12'd0, wb_reg}, 16'h3);
      check("wb_data_r3", wb_data, 16'h1234);
      drain();

      // Load-use: one stall cycle, then mem_result forwarded from MEM
      ex_result = 16'h0000; mem_result = 16'h0000;
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
      step();
      issue(4'd0, 1'b0, 4'd5, 1'b1, 4'd8, 1'b1, 1'b0);
      #1;
      check("lu_stall_on", {15'd0, stall}, 16'h1);
      step();
      mem_result = 16'hBEEF;
      #1;
      check("lu_stall_off", {15'd0, stall}, 16'h0);
      check("lu_op2_mem",   op2, 16'hBEEF);
      step();
      idle();
      mem_result = 16'h0000;
      #1;
      check("lu_wb_wen",  {15'd0, wb_wen}, 16'h1);
      check("lu_wb_reg",  {12'd0, wb_reg}, 16'h5);
      check("lu_wb_data", wb_data, 16'hBEEF);
      drain();

      // Unused source must not stall even when it names the load target
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
      step();
      issue(4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("unused_src_no_stall", {15'd0, stall}, 16'h0);
      drain();

      // Youngest writer wins: EX over MEM
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
      step();
      ex_result = 16'h0002;
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
      step();
      ex_result = 16'h0001;
      rf_rdata1 = 16'h0BAD;
      issue(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("ex_over_mem_op1", op1, 16'h0001);
      drain();

      // WB-only producer forwarded while register file still returns the old value
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
      step();
      ex_result = 16'h00C3;
      idle();
      step();
      ex_result = 16'h0000;
      step();
      issue(4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("wb_fwd_op1",   op1, 16'h00C3);
      check("wb_fwd_wen",   {15'd0, wb_wen}, 16'h1);
      drain();

      // Writes to R0 are dropped; R0 always reads zero
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
      step();
      ex_result = 16'hFFFF;
      rf_rdata1 = 16'h1111;
      issue(4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("r0_op1_zero", op1, 16'h0000);
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("r0_no_wb_%0d", i), {15'd0, wb_wen}, 16'h0);
      end
      drain();

      // Flush coincident with a load-use hazard
      ex_result = 16'h0000;
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
      step();
      issue(4'd5, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      check("flush_stall_off", {15'd0, stall}, 16'h0);
      step();
      flush = 1'b0;
      idle();
      step();
      check("flush_load_wb_reg", {12'd0, wb_reg}, 16'h5);
      step();
      check("flush_no_wb", {15'd0, wb_wen}, 16'h0);
      drain();

      // Asynchronous reset between edges with all three slots occupied
      rf_rdata1 = 16'h2222;
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
      step();
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
      step();
      issue(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
      step();
      idle();
      src1 = 4'd2;
      #1;
      check("pre_rst_wb_wen", {15'd0, wb_wen}, 16'h1);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_wb_wen", {15'd0, wb_wen}, 16'h0);
      check("async_rst_op1_rf", op1, 16'h2222);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post_rst_no_wb_%0d", i), {15'd0, wb_wen}, 16'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/operand_bypass_unit.md
OPERAND_BYPASS_UNIT -- requirements
Module: operand_bypass_unit

Interface
REQ-001 SHALL have clk, input, 1: single clock; all state updates on posedge clk.
REQ-002 SHALL have rst, input, 1: reset, asynchronous and active-high.
REQ-003 SHALL have id_valid, input, 1: decode stage holds a real instruction.
REQ-004 SHALL have src1/src2, input, 4 each: source register IDs driven to the register file read ports.
REQ-005 SHALL have src1_used/src2_used, input, 1 each: the instruction actually reads that source.
REQ-006 SHALL have dst, input, 4; dst_we, input, 1; is_load, input, 1: destination of the decode-stage instruction.
REQ-007 SHALL have rf_rdata1/rf_rdata2, input, 16 each: register file read bitlines.
REQ-008 SHALL have ex_result, input, 16: ALU result of the EX-stage instruction; mem_result, input, 16: load data of the MEM-stage instruction.
REQ-009 SHALL have flush, input, 1: squash the decode-stage instruction.
REQ-010 SHALL have op1/op2, output, 16 each: resolved operands to the ID/EX register.
REQ-011 SHALL have stall, output, 1: hold PC and IF/ID this cycle.
REQ-012 SHALL have wb_wen, output, 1; wb_reg, output, 4; wb_data, output, 16: register file write port (WriteReg, RegId, D).

Function
REQ-013 SHALL track three slots EX, MEM, WB; each holds valid, dst, is_load, data (16 bits).
REQ-014 SHALL load EX on each posedge: {id_valid & dst_we & dst!=0, dst, is_load} when stall=0 and flush=0; otherwise a bubble (valid=0).
REQ-015 SHALL advance MEM<=EX each cycle, capturing data=ex_result (don't-care for loads).
REQ-016 SHALL advance WB<=MEM each cycle, capturing data=mem_result if MEM.is_load, else MEM.data.
REQ-017 SHALL drive wb_wen=WB.valid, wb_reg=WB.dst, wb_data=WB.data combinationally.
REQ-018 SHALL resolve opN combinationally by priority: srcN==0 -> 0; EX.valid & !EX.is_load & EX.dst==srcN -> ex_result; MEM match -> MEM load ? mem_result : MEM.data; WB match -> WB.data; else rf_rdata N.
REQ-019 SHALL assert stall when id_valid & EX.valid & EX.is_load & ((src1_used & src1==EX.dst) | (src2_used & src2==EX.dst)); zero-cycle combinational path.
REQ-020 SHALL give flush priority: flush=1 forces EX bubble and suppresses stall.
REQ-021 SHALL forward WB even though it writes the register file the same edge (register file reads return pre-write value).
REQ-022 SHALL ignore src*_used for forwarding selection (only for stall); unused operand values are don't-care.
REQ-023 SHALL resolve a load-use hazard in exactly one stall cycle; next cycle the load sits in MEM and forwards mem_result.
REQ-024 SHALL never write register 0 (dst==0 never sets slot valid).

Reset
REQ-025 SHALL clear all slot valid bits and dst/data fields asynchronously on rst=1.
REQ-026 SHALL hold wb_wen=0, stall=0 during and after reset until a load enters EX; op1/op2 equal rf_rdata (or 0 for R0) while slots are invalid.
REQ-027 SHALL discard in-flight writes when reset asserts mid-operation; no write issued on the first post-reset edge.

Structure
REQ-028 SHALL take REG_W=16, REG_ID_W=4, NUM_REGS=16, ZERO_REG=0 from the shared processor package.
REQ-029 SHALL implement each slot as one sub-module instance, bypass_slot (valid, dst, is_load, data with load-enable and async clear), instantiated three times.
REQ-030 SHALL keep forwarding mux and stall logic in the top module.

Verification
REQ-031 SHALL cover: ADD R3 (ex_result=0x1234) then ADD using R3 -> op1=0x1234 next cycle, stall=0.
REQ-032 SHALL cover: LW R5 then consumer of R5, mem_result=0xBEEF -> stall=1 one cycle, then op2=0xBEEF, stall=0.
REQ-033 SHALL cover: writes to R4 in EX (0x0001) and MEM (0x0002) -> op1=0x0001 (youngest wins); writes to R4 in WB only -> op1=WB.data while rf_rdata1 old.
REQ-034 SHALL cover: instruction with dst=R0, ex_result=0xFFFF, then consumer of R0 -> op1=0, wb_wen never 1.
REQ-035 SHALL cover: load-use stall coincident with flush=1 -> stall=0, EX bubble, no wb_wen three cycles later.
REQ-036 SHALL cover: rst pulsed asynchronously between edges with three valid slots -> wb_wen=0 immediately, no writes after release.
